// File: rtl/sgpr_pkg.sv
// sgpr_pkg
// Shared sizes and types for the SGPR read path.
//   SGPR_REQ_SIZE  : width of one read request payload
//   SGPR_RESP_SIZE : width of one read response payload
//   SGPR_MAX_REQ   : largest requester count any arbiter instance supports
//   sgpr_req_id_t  : requester ID, wide enough for SGPR_MAX_REQ requesters
package sgpr_pkg;

    localparam int SGPR_REQ_SIZE  = 16;
    localparam int SGPR_RESP_SIZE = 32;
    localparam int SGPR_MAX_REQ   = 8;
    localparam int SGPR_ID_W      = $clog2(SGPR_MAX_REQ);

    typedef logic [SGPR_ID_W-1:0] sgpr_req_id_t;

    // Next requester after id, wrapping at num_req.
    function automatic sgpr_req_id_t sgpr_id_inc(input sgpr_req_id_t id, input int num_req);
        sgpr_req_id_t nxt;
        if (int'(id) == num_req - 1) begin
            nxt = '0;
        end else begin
            nxt = id + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sgpr_tag_fifo.sv
// sgpr_tag_fifo
// In-order FIFO holding the requester ID of every read still waiting for
// its response. DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears pointers)
//   push        : write push_data (ignored when full)
//   push_data   : tag to store
//   pop         : drop the head entry (ignored when empty)
//   pop_data    : current head entry
//   full, empty : occupancy flags
module sgpr_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sgpr_rd_arbiter.sv
// sgpr_rd_arbiter
// Round-robin arbiter sharing one SGPR read port among NUM_REQ requesters.
// Accepted requests go through a single output register (latency 1); the
// requester ID is queued in order so each response is routed back to the
// requester that issued it.
// Build option: SGPR_ARB_PRIO0_EN -- requester 0 gets strict priority and the
// rest share round-robin; the default build is pure round-robin.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   req_valid/req_ready/req_data  : per-requester request channels
//   resp_valid/resp_ready         : per-requester response handshake
//   resp_data                     : response payload, broadcast to all
//   sgpr_req_valid/ready/data     : request link to the SGPR read port
//   sgpr_resp_valid/ready/data    : response link from the SGPR read port
//   outstanding                   : number of requests awaiting a response
module sgpr_rd_arbiter
    import sgpr_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*SGPR_REQ_SIZE-1:0]     req_data,
    output logic [NUM_REQ-1:0]                   resp_valid,
    input  logic [NUM_REQ-1:0]                   resp_ready,
    output logic [SGPR_RESP_SIZE-1:0]            resp_data,
    output logic                                 sgpr_req_valid,
    input  logic                                 sgpr_req_ready,
    output logic [SGPR_REQ_SIZE-1:0]             sgpr_req_data,
    input  logic                                 sgpr_resp_valid,
    output logic                                 sgpr_resp_ready,
    input  logic [SGPR_RESP_SIZE-1:0]            sgpr_resp_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

    localparam int                OW       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0]     OUTS_MAX = OW'(MAX_OUTSTANDING);

    sgpr_req_id_t             rr_ptr;
    sgpr_req_id_t             grant_id;
    sgpr_req_id_t             head_id;
    logic                     grant_found;
    logic                     accept;
    logic                     resp_fire;
    logic                     tag_full;
    logic                     tag_empty;
    logic [SGPR_ID_W:0]       idx;
    logic [SGPR_MAX_REQ-1:0]  cand;
    logic [SGPR_MAX_REQ-1:0]  resp_ready_ext;
    logic [SGPR_REQ_SIZE-1:0] req_data_arr [SGPR_MAX_REQ];

    // Unpack payloads into a fixed-size array so a requester-ID index is
    // always exactly SGPR_ID_W bits wide.
    for (genvar g = 0; g < SGPR_MAX_REQ; g++) begin : g_unpack
        if (g < NUM_REQ) begin : g_live
            assign req_data_arr[g] = req_data[g*SGPR_REQ_SIZE +: SGPR_REQ_SIZE];
        end else begin : g_tie
            assign req_data_arr[g] = '0;
        end
    end

    assign resp_ready_ext = SGPR_MAX_REQ'(resp_ready);

    // Round-robin search from rr_ptr upward, modulo NUM_REQ.
    always_comb begin
        cand = SGPR_MAX_REQ'(req_valid);
`ifdef SGPR_ARB_PRIO0_EN
        cand[0] = 1'b0;
`endif
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (SGPR_ID_W+1)'(k);
            if (idx >= (SGPR_ID_W+1)'(NUM_REQ)) begin
                idx = idx - (SGPR_ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && cand[idx[SGPR_ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = idx[SGPR_ID_W-1:0];
            end
        end
`ifdef SGPR_ARB_PRIO0_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
            grant_id    = '0;
        end
`endif
    end

    // A response popped this cycle does not free a slot for this cycle's
    // accept; only the registered count is compared. The rst_n term keeps
    // req_ready low while reset is held even though the registers are idle.
    assign accept = rst_n && grant_found
                 && (!sgpr_req_valid || sgpr_req_ready)
                 && (outstanding < OUTS_MAX) && !tag_full;

    assign resp_fire       = sgpr_resp_valid && sgpr_resp_ready;
    assign sgpr_resp_ready = !tag_empty && resp_ready_ext[head_id];
    assign resp_data       = sgpr_resp_data;

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i]  = accept && (grant_id == SGPR_ID_W'(i));
            resp_valid[i] = !tag_empty && sgpr_resp_valid && (head_id == SGPR_ID_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr         <= '0;
            sgpr_req_valid <= 1'b0;
            sgpr_req_data  <= '0;
            outstanding    <= '0;
        end else begin
            if (accept) begin
                sgpr_req_valid <= 1'b1;
                sgpr_req_data  <= req_data_arr[grant_id];
`ifdef SGPR_ARB_PRIO0_EN
                // Priority grants to requester 0 leave the rotation alone.
                if (grant_id != '0) begin
                    rr_ptr <= sgpr_id_inc(grant_id, NUM_REQ);
                end
`else
                rr_ptr <= sgpr_id_inc(grant_id, NUM_REQ);
`endif
            end else if (sgpr_req_ready) begin
                sgpr_req_valid <= 1'b0;
            end

            if (accept && !resp_fire) begin
                outstanding <= outstanding + 1'b1;
            end else if (!accept && resp_fire) begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

    sgpr_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (SGPR_ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (grant_id),
        .pop       (resp_fire),
        .pop_data  (head_id),
        .full      (tag_full),
        .empty     (tag_empty)
    );

endmodule

// File: doc/sgpr_rd_arbiter.md
SGPR_RD_ARBITER -- requirements
Module: sgpr_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of read requesters (2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum read requests issued but not yet answered (power of two, 2..16).
REQ-003 SHALL have ports `clk` (in, 1, sole clock) and `rst_n` (in, 1, reset); one clock, reset asynchronous, active-low.
REQ-004 SHALL have port req_valid, in, NUM_REQ, per-requester request valid.
REQ-005 SHALL have port req_ready, out, NUM_REQ, per-requester request accepted.
REQ-006 SHALL have port req_data, in, NUM_REQ*SGPR_REQ_SIZE, per-requester request payload; requester i occupies slice i.
REQ-007 SHALL have port resp_valid, out, NUM_REQ, per-requester response valid.
REQ-008 SHALL have port resp_ready, in, NUM_REQ, per-requester response accept.
REQ-009 SHALL have port resp_data, out, SGPR_RESP_SIZE, response payload, broadcast to all requesters.
REQ-010 SHALL have ports sgpr_req_valid (out, 1), sgpr_req_ready (in, 1) and sgpr_req_data (out, SGPR_REQ_SIZE), forming the request link to the SGPR read port.
REQ-011 SHALL have ports sgpr_resp_valid (in, 1), sgpr_resp_ready (out, 1) and sgpr_resp_data (in, SGPR_RESP_SIZE), forming the response link from the SGPR read port.
REQ-012 SHALL have port outstanding, out, $clog2(MAX_OUTSTANDING+1), count of in-flight requests.

Function
REQ-013 A transfer SHALL occur on any valid/ready pair when both are high at a rising clk edge.
REQ-014 Once valid is asserted, the data SHALL be held stable until the transfer completes.
REQ-015 At most one req_ready bit SHALL be high per cycle.
REQ-016 req_ready[i] SHALL be high only when all of the following hold: i is the grant winner, the output register is empty or draining this cycle, and outstanding < MAX_OUTSTANDING (a pop in the same cycle does not count).
REQ-017 Grant SHALL be round-robin: search from rr_ptr upward, modulo NUM_REQ, for the first set req_valid bit.
REQ-018 After each accepted request from requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; otherwise rr_ptr SHALL be unchanged.
REQ-019 An accepted request SHALL be registered and presented on sgpr_req_valid/sgpr_req_data the next cycle (latency 1), held until sgpr_req_ready.
REQ-020 Back-to-back requests SHALL sustain one per cycle while sgpr_req_ready stays high.
REQ-021 On acceptance, requester ID i SHALL be pushed into an in-order tag FIFO of depth MAX_OUTSTANDING.
REQ-022 When the FIFO is non-empty with head ID h: resp_valid[h] SHALL equal sgpr_resp_valid, other resp_valid bits SHALL be 0, and sgpr_resp_ready SHALL equal resp_ready[h].
REQ-023 The FIFO SHALL pop on the sgpr_resp handshake.
REQ-024 When the FIFO is empty, sgpr_resp_ready SHALL be 0 and resp_valid SHALL be all 0, so an unexpected response stalls.
REQ-025 outstanding SHALL count +1 on accept and -1 on response handshake, and SHALL be unchanged when both occur in the same cycle.
REQ-026 outstanding SHALL never exceed MAX_OUTSTANDING and SHALL never underflow.
REQ-027 FIFO read and write pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-028 While rst_n is low, the following SHALL be cleared: rr_ptr=0, output register valid=0, FIFO pointers=0, outstanding=0.
REQ-029 In reset, all ready/valid outputs SHALL be 0; sgpr_req_data and resp_data are don't-care.
REQ-030 A reset asserted mid-operation SHALL discard in-flight tags.
REQ-031 A response arriving after reset SHALL stall per REQ-024.

Configuration
REQ-032 With macro SGPR_ARB_PRIO0_EN defined, requester 0 SHALL win whenever req_valid[0] is high; the remaining requesters arbitrate round-robin, and rr_ptr is updated only on non-zero grants.
REQ-033 Without SGPR_ARB_PRIO0_EN, pure round-robin per REQ-017 SHALL apply to all requesters.

Structure
REQ-034 SGPR_REQ_SIZE and SGPR_RESP_SIZE SHALL come from sgpr_pkg.
REQ-035 A requester-ID typedef SHALL be added to sgpr_pkg.
REQ-036 The tag FIFO SHALL be sub-module sgpr_tag_fifo, parameterised by depth and width, with push/pop/full/empty.

Verification
REQ-037 Reset test: hold rst_n low with all inputs active -> req_ready=0, sgpr_req_valid=0, resp_valid=0, outstanding=0.
REQ-038 Round-robin test: req_valid=4'b1111, sgpr_req_ready=1, responses returned immediately -> grants 0,1,2,3,0 on consecutive cycles, sgpr_req_valid high from cycle 2.
REQ-039 Full test: MAX_OUTSTANDING=4, sgpr_req_ready=1, no responses -> 4 accepts, outstanding=4, req_ready=0 thereafter; a single response -> outstanding=3 and one further accept.
REQ-040 Routing test: requests from IDs 2, 0, 3, then responses R1..R3 -> resp_valid = 4'b0100, 4'b0001, 4'b1000 in order; resp_ready[0]=0 on the second response stalls it and sgpr_resp_ready=0.
REQ-041 Simultaneous test: accept and response handshake in the same cycle at outstanding=2 -> outstanding stays 2.
REQ-042 Priority test (SGPR_ARB_PRIO0_EN defined): req_valid[0] high continuously with req_valid[1]=1 -> every grant goes to requester 0 until req_valid[0] drops, then requester 1 is granted.
